sha_job_dispatcher: RTL and testbench

//  Work scheduler for N parallel sha256 cracking cores. Owns one shared candidate counter
//  (9-digit ASCII decimal), hands the next candidate to any idle core (round-robin), and

---
 rtl/sha_crack_pkg.sv | 12 +
 rtl/sha_job_dispatcher_bcd_ascii_incr.sv | 30 +++
 rtl/sha_job_dispatcher.sv | 180 ++++++++++++++++++
 tb/tb_sha_job_dispatcher.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/sha_crack_pkg.sv
// Shared constants and types for the sha256 cracking job dispatcher.
package sha_crack_pkg;

    localparam int         DIGITS     = 9;
    localparam int         MSG_W      = 8 * DIGITS;
    localparam int         HASH_W     = 256;
    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_NINE = 8'h39;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

endpackage

// File: rtl/sha_job_dispatcher_bcd_ascii_incr.sv
// Combinational +1 on a string of ASCII decimal digits (byte 0 = least significant digit).
module bcd_ascii_incr
    import sha_crack_pkg::*;
#(
    parameter int DIGITS = sha_crack_pkg::DIGITS
) (
    input  logic [8*DIGITS-1:0] value_i,
    output logic [8*DIGITS-1:0] value_o,
    output logic                carry_o
);

    logic carry;

    always_comb begin
        carry   = 1'b1;
        value_o = value_i;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (value_i[8*i +: 8] == ASCII_NINE) begin
                    value_o[8*i +: 8] = ASCII_ZERO;
                end else begin
                    value_o[8*i +: 8] = value_i[8*i +: 8] + 8'd1;
                    carry             = 1'b0;
                end
            end
        end
        carry_o = carry;
    end

endmodule

// File: rtl/sha_job_dispatcher.sv
// Round-robin candidate dispatcher for N sha256 cores with match/exhaustion detection.
// Optional feature: define DISPATCH_PROGRESS_EN to add progress_o (last dispatched candidate).
module sha_job_dispatcher
    import sha_crack_pkg::*;
#(
    parameter int  N_CORES = 5,
    parameter int  DIGITS  = sha_crack_pkg::DIGITS,
    localparam int MSG_W   = 8 * DIGITS
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             start_i,
    input  logic                             abort_i,
    input  logic [HASH_W-1:0]                target_hash_i,
    output logic [N_CORES-1:0]               core_start_o,
    output logic [N_CORES-1:0][MSG_W-1:0]    core_msg_o,
    input  logic [N_CORES-1:0]               core_done_i,
    input  logic [N_CORES-1:0][HASH_W-1:0]   core_hash_i,
    output logic                             busy_o,
    output logic                             found_o,
    output logic                             exhausted_o,
    output logic [MSG_W-1:0]                 answer_o,
    output logic [55:0]                      cycles_o
`ifdef DISPATCH_PROGRESS_EN
    ,
    output logic [MSG_W-1:0]                 progress_o
`endif
);

    localparam int               IDX_W    = (N_CORES > 1) ? $clog2(N_CORES) : 1;
    localparam logic [MSG_W-1:0] ZERO_STR = {DIGITS{ASCII_ZERO}};

    state_e                          state_q;
    logic [MSG_W-1:0]                cnt_q, cnt_src, cnt_d;
    logic                            cnt_carry;
    logic [N_CORES-1:0]              idle_q, idle_d, start_q, done_vld;
    logic [IDX_W-1:0]                rr_q, rr_d, pick_idx, match_idx;
    logic                            pick_vld, match_any, dispatch, start_acc, active;
    int                              pj;
    logic [N_CORES-1:0][MSG_W-1:0]   msg_q;
    logic [HASH_W-1:0]               target_q;
    logic                            busy_q, found_q, exh_q;
    logic [MSG_W-1:0]                answer_q;
    logic [55:0]                     cycles_q;

    assign start_acc = start_i && (state_q == IDLE || state_q == DONE);
    assign active    = (state_q == RUN) || (state_q == DRAIN);
    // The start edge itself hands out "0..0", so the first core_start follows start by one cycle.
    assign cnt_src   = start_acc ? ZERO_STR : cnt_q;
    assign done_vld  = core_done_i & ~idle_q;

    bcd_ascii_incr #(.DIGITS(DIGITS)) u_incr (
        .value_i (cnt_src),
        .value_o (cnt_d),
        .carry_o (cnt_carry)
    );

    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        pj       = 0;
        for (int k = 0; k < N_CORES; k++) begin
            pj = int'(rr_q) + k;
            if (pj >= N_CORES) pj = pj - N_CORES;
            if (!pick_vld && idle_q[pj]) begin
                pick_vld = 1'b1;
                pick_idx = IDX_W'(pj);
            end
        end
    end

    // Scan high to low so the lowest matching core is the one left standing.
    always_comb begin
        match_any = 1'b0;
        match_idx = '0;
        for (int i = N_CORES - 1; i >= 0; i--) begin
            if (active && done_vld[i] && core_hash_i[i] == target_q) begin
                match_any = 1'b1;
                match_idx = IDX_W'(i);
            end
        end
    end

    assign dispatch = pick_vld && (start_acc || (state_q == RUN && !match_any));

    always_comb begin
        idle_d = idle_q | done_vld;
        if (dispatch) idle_d[pick_idx] = 1'b0;
        rr_d = (int'(pick_idx) == N_CORES - 1) ? '0 : pick_idx + 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= ZERO_STR;
            idle_q   <= '1;
            rr_q     <= '0;
            start_q  <= '0;
            msg_q    <= '0;
            target_q <= '0;
            busy_q   <= 1'b0;
            found_q  <= 1'b0;
            exh_q    <= 1'b0;
            answer_q <= '0;
            cycles_q <= '0;
        end else if (abort_i) begin
            state_q  <= IDLE;
            cnt_q    <= ZERO_STR;
            idle_q   <= '1;
            rr_q     <= '0;
            start_q  <= '0;
            msg_q    <= '0;
            busy_q   <= 1'b0;
            found_q  <= 1'b0;
            exh_q    <= 1'b0;
            answer_q <= '0;
            cycles_q <= '0;
        end else begin
            start_q <= '0;
            idle_q  <= idle_d;
            if (dispatch) begin
                start_q[pick_idx] <= 1'b1;
                msg_q[pick_idx]   <= cnt_src;
                cnt_q             <= cnt_d;
                rr_q              <= rr_d;
            end
            if (active && !(&cycles_q)) cycles_q <= cycles_q + 56'd1;
            case (state_q)
                IDLE, DONE: begin
                    if (start_i) begin
                        state_q  <= RUN;
                        target_q <= target_hash_i;
                        busy_q   <= 1'b1;
                        found_q  <= 1'b0;
                        exh_q    <= 1'b0;
                        answer_q <= '0;
                        cycles_q <= '0;
                        if (!dispatch) cnt_q <= ZERO_STR;
                    end
                end
                RUN, DRAIN: begin
                    if (match_any) begin
                        state_q  <= DONE;
                        busy_q   <= 1'b0;
                        found_q  <= 1'b1;
                        answer_q <= msg_q[match_idx];
                    end else if (state_q == RUN && dispatch && cnt_carry) begin
                        state_q <= DRAIN;
                    end else if (state_q == DRAIN && (&idle_q)) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        exh_q   <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef DISPATCH_PROGRESS_EN
    logic [MSG_W-1:0] progress_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)      progress_q <= ZERO_STR;
        else if (abort_i)  progress_q <= ZERO_STR;
        else if (dispatch) progress_q <= cnt_src;
    end

    assign progress_o = progress_q;
`endif

    assign core_start_o = start_q;
    assign core_msg_o   = msg_q;
    assign busy_o       = busy_q;
    assign found_o      = found_q;
    assign exhausted_o  = exh_q;
    assign answer_o     = answer_q;
    assign cycles_o     = cycles_q;

endmodule

// File: tb/tb_sha_job_dispatcher.sv
// Directed bench: 5 mock cores (latency 4, hash = zero-padded msg), 2-digit keyspace.
module tb_sha_job_dispatcher;

    localparam int N   = 5;
    localparam int D   = 2;
    localparam int MW  = 8 * D;
    localparam int LAT = 4;

    localparam logic [15:0] S00 = "00";
    localparam logic [15:0] S01 = "01";
    localparam logic [15:0] S03 = "03";
    localparam logic [15:0] S05 = "05";
    localparam logic [15:0] S07 = "07";
    localparam logic [15:0] S99 = "99";

    logic                       clk = 1'b0;
    logic                       reset_n, start, abort;
    logic [255:0]               target_hash;
    logic [N-1:0]               core_start;
    logic [N-1:0][MW-1:0]       core_msg;
    logic [N-1:0]               core_done;
    logic [N-1:0][255:0]        core_hash;
    logic                       busy, found, exhausted;
    logic [MW-1:0]              answer;
    logic [55:0]                cycles;
`ifdef DISPATCH_PROGRESS_EN
    logic [MW-1:0]              progress;
`endif

    int                         mcnt [N] = '{default: 0};
    logic [MW-1:0]              mmsg [N] = '{default: '0};
    logic [N-1:0]               mdone = '0;
    bit                         mock_en;
    logic [N-1:0]               spur;
    logic [255:0]               spur_hash;
    int                         disp_cnt = 0;
    int                         disp_idx [256];
    logic [MW-1:0]              disp_msg [256];
    logic [MW-1:0]              last_msg = '0;

    int n_cmp = 0;
    int n_err = 0;
    int base, n;
    bit seen99;

    always #5 clk = ~clk;

    sha_job_dispatcher #(.N_CORES(N), .DIGITS(D)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start_i       (start),
        .abort_i       (abort),
        .target_hash_i (target_hash),
        .core_start_o  (core_start),
        .core_msg_o    (core_msg),
        .core_done_i   (core_done),
        .core_hash_i   (core_hash),
        .busy_o        (busy),
        .found_o       (found),
        .exhausted_o   (exhausted),
        .answer_o      (answer),
        .cycles_o      (cycles)
`ifdef DISPATCH_PROGRESS_EN
        ,
        .progress_o    (progress)
`endif
    );

    // Mock cores and dispatch monitor, both on the falling edge.
    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            mdone[i] = 1'b0;
            if (mcnt[i] != 0) begin
                mcnt[i] = mcnt[i] - 1;
                if (mcnt[i] == 0) mdone[i] = 1'b1;
            end
            if (core_start[i]) begin
                if (mock_en) begin
                    mcnt[i] = LAT;
                    mmsg[i] = core_msg[i];
                end
                if (disp_cnt < 256) begin
                    disp_idx[disp_cnt] = i;
                    disp_msg[disp_cnt] = core_msg[i];
                end
                last_msg = core_msg[i];
                disp_cnt = disp_cnt + 1;
            end
        end
    end

    always_comb begin
        core_done = '0;
        core_hash = '0;
        for (int i = 0; i < N; i++) begin
            core_done[i] = mdone[i] | spur[i];
            core_hash[i] = spur[i] ? spur_hash : {240'h0, mmsg[i]};
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; abort = 1'b0; target_hash = '0;
        spur = '0; spur_hash = '0; mock_en = 1'b1;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        tick();
        check("rst core_start", core_start, 0);
        check("rst core_msg", core_msg, 0);
        check("rst busy", busy, 0);
        check("rst found", found, 0);
        check("rst exhausted", exhausted, 0);
        check("rst answer", answer, 0);
        check("rst cycles", cycles, 0);

        // Match on "07"
        target_hash = {240'h0, S07};
        base = disp_cnt;
        start = 1'b1; tick(); start = 1'b0;
        check("A first core_start", core_start, 5'b00001);
        check("A first msg", core_msg[0], S00);
        check("A busy", busy, 1);
        n = 0;
        while (!found && n < 60) begin tick(); n++; end
        check("A found latency", n, 13);
        check("A found", found, 1);
        check("A answer", answer, S07);
        check("A busy after", busy, 0);
        check("A exhausted", exhausted, 0);
        check("A cycles", cycles, 13);
        for (int k = 0; k < 6; k++) check("A rr order", disp_idx[base + k], k % N);
        check("A sixth msg", disp_msg[base + 5], S05);
        repeat (4) tick();
        check("A answer sticky", answer, S07);
        check("A cycles hold", cycles, 13);
        check("A dispatch count", disp_cnt - base, 11);

        abort = 1'b1; tick(); abort = 1'b0;
        repeat (10) tick();
        check("abort found", found, 0);
        check("abort answer", answer, 0);

        // Abort during RUN with three cores busy
        target_hash = '1;
        base = disp_cnt;
        start = 1'b1; tick(); start = 1'b0;
        tick(); tick();
        check("B three dispatched", disp_cnt - base, 3);
        check("B cycles pre", cycles, 2);
        abort = 1'b1; tick(); abort = 1'b0;
        check("B busy", busy, 0);
        check("B cycles", cycles, 0);
        check("B core_start", core_start, 0);
        check("B core_msg", core_msg, 0);
        repeat (8) tick();
        check("B no dispatch", disp_cnt - base, 3);
        check("B found", found, 0);
        check("B busy late", busy, 0);

        // Spurious done on idle core, then run to exhaustion
        target_hash = {240'h0, 16'h5A5A};
        spur_hash = target_hash;
        base = disp_cnt;
        seen99 = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        spur = 5'b01000; tick(); spur = '0;
        check("C spurious found", found, 0);
        check("C second dispatch", core_start, 5'b00010);
        n = 0;
        while (!exhausted && !found && n < 400) begin
            tick(); n++;
            if (!seen99 && last_msg == S99) begin
                seen99 = 1'b1;
                check("D drain busy", busy, 1);
                check("D drain not exhausted", exhausted, 0);
            end
        end
        check("D seen 99", seen99, 1);
        check("D exhausted", exhausted, 1);
        check("D found", found, 0);
        check("D busy", busy, 0);
        check("D dispatch count", disp_cnt - base, 100);
        check("D last dispatch", last_msg, S99);
        check("D cycles", cycles, 124);
`ifdef DISPATCH_PROGRESS_EN
        check("D progress", progress, S99);
`endif

        // Cores 1 and 3 match in the same cycle
        mock_en = 1'b0;
        target_hash = {240'h0, 16'h4142};
        spur_hash = target_hash;
        start = 1'b1; tick(); start = 1'b0;
        check("E exhausted cleared", exhausted, 0);
        check("E busy", busy, 1);
        check("E first start", core_start, 5'b00001);
        repeat (4) tick();
        check("E msg core1", core_msg[1], S01);
        check("E msg core3", core_msg[3], S03);
        spur = 5'b01010; tick(); spur = '0;
        check("E found", found, 1);
        check("E answer lowest", answer, S01);
        check("E busy", busy, 0);
        check("E cycles", cycles, 5);
        check("E no dispatch", core_start, 0);
        abort = 1'b1; tick(); abort = 1'b0;
        check("E abort found", found, 0);
        check("E abort answer", answer, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
